// File: rtl/int_ctrl.sv
// Interrupt controller: edge/level sources, pending/enable/mode registers, a claim register and
// an IDLE/ACTIVE/ACKED request FSM. Define INT_CTRL_SYNC_EN to add 2-flop input synchronizers.
module int_ctrl #(
    parameter int unsigned        NUM_INT  = 8,
    parameter logic [NUM_INT-1:0] DEF_MODE = {NUM_INT{1'b1}}
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_INT-1:0] irq_in,
    input  logic               ins_ack,
    output logic               irq,
    input  logic               i_wb_cyc,
    input  logic [1:0]         i_wb_adr,
    input  logic               i_wb_we,
    input  logic [31:0]        i_wb_data,
    output logic [31:0]        o_wb_rdt,
    output logic               o_wb_ack
);

    typedef enum logic [1:0] {StIdle, StActive, StAcked} state_e;

    state_e             state_q, state_d;
    logic [NUM_INT-1:0] pend_q, pend_d;
    logic [NUM_INT-1:0] ie_q, ie_d;
    logic [NUM_INT-1:0] mode_q, mode_d;
    logic [NUM_INT-1:0] hist_q;
    logic [NUM_INT-1:0] samp;
    logic [NUM_INT-1:0] set_ev;
    logic [NUM_INT-1:0] w1c;
    logic [NUM_INT-1:0] fire;
    logic [31:0]        claim;
    logic               ack_q;
    logic               irq_q;
    logic               wr_en;
    logic               pend_rise;
    logic               unused_wdata;

`ifdef INT_CTRL_SYNC_EN
    logic [NUM_INT-1:0] sync1_q, sync2_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= irq_in;
            sync2_q <= sync1_q;
        end
    end

    assign samp = sync2_q;
`else
    assign samp = irq_in;
`endif

    assign unused_wdata = ^i_wb_data;
    assign wr_en        = i_wb_cyc & i_wb_we & ack_q;
    assign set_ev       = (mode_q & samp & ~hist_q) | (~mode_q & samp);
    assign fire         = pend_q & ie_q;
    assign pend_rise    = |(pend_d & ~pend_q);

    always_comb begin
        ie_d   = ie_q;
        mode_d = mode_q;
        w1c    = '0;
        if (wr_en) begin
            case (i_wb_adr)
                2'd0:    w1c    = i_wb_data[NUM_INT-1:0];
                2'd1:    ie_d   = i_wb_data[NUM_INT-1:0];
                2'd2:    mode_d = i_wb_data[NUM_INT-1:0];
                default: ;
            endcase
        end
        // A set event in the same cycle as its clear wins.
        pend_d = (pend_q & ~w1c) | set_ev;
    end

    always_comb begin
        claim = '0;
        if (|fire) begin
            claim[31] = 1'b1;
            for (int i = int'(NUM_INT) - 1; i >= 0; i--) begin
                if (fire[i]) claim[4:0] = 5'(i);
            end
        end
    end

    always_comb begin
        o_wb_rdt = '0;
        case (i_wb_adr)
            2'd0:    o_wb_rdt[NUM_INT-1:0] = pend_q;
            2'd1:    o_wb_rdt[NUM_INT-1:0] = ie_q;
            2'd2:    o_wb_rdt[NUM_INT-1:0] = mode_q;
            default: o_wb_rdt = claim;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (|fire) state_d = StActive;
            end
            StActive: begin
                if (ins_ack)     state_d = StAcked;
                else if (~|fire) state_d = StIdle;
            end
            StAcked: begin
                // A freshly pending source re-arms the request.
                if (~|fire || pend_rise) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            irq_q   <= 1'b0;
            ack_q   <= 1'b0;
            pend_q  <= '0;
            ie_q    <= '0;
            mode_q  <= DEF_MODE;
            hist_q  <= '0;
        end else begin
            state_q <= state_d;
            irq_q   <= (state_d == StActive);
            ack_q   <= i_wb_cyc & ~ack_q;
            pend_q  <= pend_d;
            ie_q    <= ie_d;
            mode_q  <= mode_d;
            hist_q  <= samp;
        end
    end

    assign irq      = irq_q;
    assign o_wb_ack = ack_q;

endmodule

// File: tb/tb_int_ctrl.sv
// Directed testbench for int_ctrl (NUM_INT = 8): register table plus hand-written corner sequences.
module tb_int_ctrl;

    localparam int NumInt = 8;
`ifdef INT_CTRL_SYNC_EN
    localparam int SyncLat = 2;
`else
    localparam int SyncLat = 0;
`endif

    logic              clk;
    logic              rst;
    logic [NumInt-1:0] irq_in;
    logic              ins_ack;
    logic              irq;
    logic              i_wb_cyc;
    logic [1:0]        i_wb_adr;
    logic              i_wb_we;
    logic [31:0]       i_wb_data;
    logic [31:0]       o_wb_rdt;
    logic              o_wb_ack;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic [1:0]  adr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } reg_vec_t;

    reg_vec_t vecs[6];

    int_ctrl #(.NUM_INT(NumInt)) dut (
        .clk       (clk),
        .rst       (rst),
        .irq_in    (irq_in),
        .ins_ack   (ins_ack),
        .irq       (irq),
        .i_wb_cyc  (i_wb_cyc),
        .i_wb_adr  (i_wb_adr),
        .i_wb_we   (i_wb_we),
        .i_wb_data (i_wb_data),
        .o_wb_rdt  (o_wb_rdt),
        .o_wb_ack  (o_wb_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic rd_check(input string name, input logic [1:0] adr, input logic [31:0] exp);
        i_wb_adr = adr;
        #1;
        check(name, o_wb_rdt, exp);
    endtask

    // Commit happens on the second edge, when the registered ack is high.
    task automatic bus_write(input logic [1:0] adr, input logic [31:0] data);
        i_wb_cyc  = 1'b1;
        i_wb_we   = 1'b1;
        i_wb_adr  = adr;
        i_wb_data = data;
        tick();
        tick();
        i_wb_cyc  = 1'b0;
        i_wb_we   = 1'b0;
    endtask

    initial begin
        int cnt;

        vecs[0] = '{name: "ie_rw",      adr: 2'd1, wdata: 32'h0000_00A5, exp: 32'h0000_00A5};
        vecs[1] = '{name: "ie_upper",   adr: 2'd1, wdata: 32'hFFFF_FF00, exp: 32'h0000_0000};
        vecs[2] = '{name: "mode_rw",    adr: 2'd2, wdata: 32'h0000_000F, exp: 32'h0000_000F};
        vecs[3] = '{name: "mode_back",  adr: 2'd2, wdata: 32'h0000_00FF, exp: 32'h0000_00FF};
        vecs[4] = '{name: "claim_ro",   adr: 2'd3, wdata: 32'hFFFF_FFFF, exp: 32'h0000_0000};
        vecs[5] = '{name: "pend_w1c_0", adr: 2'd0, wdata: 32'h0000_00FF, exp: 32'h0000_0000};

        rst = 1'b1; irq_in = '0; ins_ack = 1'b0;
        i_wb_cyc = 1'b0; i_wb_adr = 2'd0; i_wb_we = 1'b0; i_wb_data = '0;
        tick();
        tick();
        rst = 1'b0;

        rd_check("rst_pend", 2'd0, 32'h0);
        rd_check("rst_ie", 2'd1, 32'h0);
        rd_check("rst_mode", 2'd2, 32'hFF);
        rd_check("rst_claim", 2'd3, 32'h0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        check("rst_ack", {31'd0, o_wb_ack}, 32'd0);

        for (int i = 0; i < 6; i++) begin
            bus_write(vecs[i].adr, vecs[i].wdata);
            rd_check(vecs[i].name, vecs[i].adr, vecs[i].exp);
        end

        // Edge pulse on source 2, then irq one cycle after PEND.
        bus_write(2'd1, 32'h04);
        irq_in = 8'h04;
        tick();
        irq_in = 8'h00;
        rd_check("e_pend", 2'd0, 32'h04);
        rd_check("e_claim", 2'd3, 32'h8000_0002);
        check("e_irq_lat0", {31'd0, irq}, 32'd0);
        tick();
        check("e_irq_lat1", {31'd0, irq}, 32'd1);

        // Acknowledge drops irq and keeps it low.
        ins_ack = 1'b1;
        tick();
        ins_ack = 1'b0;
        check("ack_irq0", {31'd0, irq}, 32'd0);
        tick();
        tick();
        check("ack_irq_hold", {31'd0, irq}, 32'd0);

        // New pending event while ACKED re-arms the request.
        irq_in = 8'h08;
        tick();
        irq_in = 8'h00;
        check("rearm_idle", {31'd0, irq}, 32'd0);
        tick();
        check("rearm_irq", {31'd0, irq}, 32'd1);
        ins_ack = 1'b1;
        tick();
        ins_ack = 1'b0;
        bus_write(2'd0, 32'h0C);
        rd_check("w1c_pend", 2'd0, 32'h0);
        tick();
        check("w1c_irq", {31'd0, irq}, 32'd0);

        // Level mode: W1C does not clear while the input is held.
        bus_write(2'd2, 32'h00);
        bus_write(2'd1, 32'h01);
        irq_in = 8'h01;
        tick();
        bus_write(2'd0, 32'h01);
        rd_check("lvl_hold", 2'd0, 32'h01);
        check("lvl_irq", {31'd0, irq}, 32'd1);
        irq_in = 8'h00;
        tick();
        bus_write(2'd0, 32'h01);
        rd_check("lvl_clr", 2'd0, 32'h0);
        tick();
        check("lvl_irq_drop", {31'd0, irq}, 32'd0);

        // Two simultaneous edges: claim reports the lowest enabled index.
        bus_write(2'd2, 32'hFF);
        bus_write(2'd1, 32'h0A);
        irq_in = 8'h0A;
        tick();
        irq_in = 8'h00;
        rd_check("two_pend", 2'd0, 32'h0A);
        rd_check("two_claim1", 2'd3, 32'h8000_0001);
        bus_write(2'd0, 32'h02);
        rd_check("two_claim3", 2'd3, 32'h8000_0003);
        bus_write(2'd0, 32'h08);
        tick();
        rd_check("two_clr", 2'd0, 32'h0);

        // Clear and rising edge on the same clock: set wins.
        i_wb_cyc = 1'b1; i_wb_we = 1'b1; i_wb_adr = 2'd0; i_wb_data = 32'h10;
        tick();
        irq_in = 8'h10;
        tick();
        i_wb_cyc = 1'b0; i_wb_we = 1'b0;
        irq_in = 8'h00;
        rd_check("set_wins", 2'd0, 32'h10);
        bus_write(2'd0, 32'h10);

        // Reset in the middle of an IE write aborts it.
        i_wb_cyc = 1'b1; i_wb_we = 1'b1; i_wb_adr = 2'd1; i_wb_data = 32'hFF;
        tick();
        rst = 1'b1;
        #1;
        check("rst_mid_ack", {31'd0, o_wb_ack}, 32'd0);
        irq_in = 8'h40;
        tick();
        i_wb_cyc = 1'b0; i_wb_we = 1'b0;
        tick();
        rst = 1'b0;
        rd_check("rst_mid_ie", 2'd1, 32'h0);
        rd_check("rst_mid_pend", 2'd0, 32'h0);
        check("rst_mid_irq", {31'd0, irq}, 32'd0);

        // Input already high at release is a rising edge; latency grows with the synchronizer.
        i_wb_adr = 2'd0;
        cnt = 0;
        #1;
        while (o_wb_rdt[6] !== 1'b1 && cnt < 10) begin
            tick();
            cnt++;
        end
        check("edge_latency", cnt, 32'(1 + SyncLat));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
